// File: rtl/mc_ctrl_pkg.sv
// Shared MIPS control encodings: opcodes, FSM states, aluop/alusrcb/pcsrc codes.
// Optional BNE support (MC_CTRL_BNE_EN) adds the BNEEX state used by mc_ctrl.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_BNEEX   = 4'd12;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // irwrite and fetch_pcwrite are requests; the top qualifies them with mem_ready.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       fetch_pcwrite;
    logic       pcwrite;
    logic       branch;
    logic       bne;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } ctl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decode; zero latency, no backpressure.
// BNEEX decodes only when MC_CTRL_BNE_EN is defined.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output ctl_t       cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.irwrite       = 1'b1;
        cw.fetch_pcwrite = 1'b1;
        cw.alusrcb       = SRCB_FOUR;
        cw.aluop         = ALUOP_ADD;
        cw.pcsrc         = PCSRC_ALU;
      end
      S_DECODE: begin
        cw.alusrcb = SRCB_IMMSH2;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMRD: cw.iord = 1'b1;
      S_MEMWB: begin
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
      end
      S_MEMWR: begin
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_RT;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        cw.regdst   = 1'b1;
        cw.regwrite = 1'b1;
      end
      S_BEQEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_RT;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNEEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_RT;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.bne     = 1'b1;
      end
`endif
      S_ADDIWB: cw.regwrite = 1'b1;
      S_JEX: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main controller: one state per clock, memory states stall on mem_ready.
// Optional MC_CTRL_BNE_EN adds bne; otherwise opcode 000101 raises illegal_op.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               pcen,
  output logic [1:0]         pcsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] nxt;
  logic               illegal;
  ctl_t               cw;

  mc_ctrl_outdec u_outdec (
    .state (state),
    .cw    (cw)
  );

  always_comb begin
    nxt     = S_FETCH;
    illegal = 1'b0;
    case (state)
      S_FETCH:   nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_RTYPEEX;
          OP_BEQ:       nxt = S_BEQEX;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JEX;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       nxt = S_BNEEX;
`endif
          default: begin
            illegal = 1'b1;
            nxt     = S_FETCH;
          end
        endcase
      end
      S_MEMADR:  nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: nxt = S_RTYPEWB;
      S_ADDIEX:  nxt = S_ADDIWB;
      default:   nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= nxt;
  end

  // Strobes are masked while reset is low so an abandoned instruction never writes.
  assign memwrite = reset & cw.memwrite;
  assign irwrite  = reset & cw.irwrite & mem_ready;
  assign regwrite = reset & cw.regwrite;
  assign pcen     = reset & (cw.pcwrite | (cw.fetch_pcwrite & mem_ready)
                             | (cw.branch & zero) | (cw.bne & ~zero));

  assign iord       = cw.iord;
  assign pcsrc      = cw.pcsrc;
  assign alusrca    = cw.alusrca;
  assign alusrcb    = cw.alusrcb;
  assign aluop      = cw.aluop;
  assign regdst     = cw.regdst;
  assign memtoreg   = cw.memtoreg;
  assign illegal_op = illegal;
  assign state_o    = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each stimulus cycle queues its expected outputs, monitor checks on negedge.
module tb_mc_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       iord, mw, irw, pcen;
    logic [1:0] pcsrc;
    logic       asa;
    logic [1:0] asb, aop;
    logic       rd, m2r, rw, ill;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       iord, memwrite, irwrite, pcen, alusrca, regdst, memtoreg, regwrite, illegal_op;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic [3:0] state_o;

  int   n_chk = 0;
  int   n_fail = 0;
  obs_t sbq[$];
  string nmq[$];

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .illegal_op(illegal_op), .state_o(state_o)
  );

  function automatic obs_t mk(input logic [3:0] st, input logic iord_e, mw, irw, pc,
                              input logic [1:0] ps, input logic asa, input logic [1:0] asb, aop,
                              input logic rd, m2r, rw, ill);
    mk = {st, iord_e, mw, irw, pc, ps, asa, asb, aop, rd, m2r, rw, ill};
  endfunction

  function automatic obs_t e_fetch(input logic b); e_fetch = mk(0, 0,0,b,b, 2'd0, 0, 2'd1, 2'd0, 0,0,0,0); endfunction
  function automatic obs_t e_decode(input logic ill); e_decode = mk(1, 0,0,0,0, 2'd0, 0, 2'd3, 2'd0, 0,0,0,ill); endfunction
  function automatic obs_t e_memadr(); e_memadr = mk(2, 0,0,0,0, 2'd0, 1, 2'd2, 2'd0, 0,0,0,0); endfunction
  function automatic obs_t e_memrd();  e_memrd  = mk(3, 1,0,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0,0,0); endfunction
  function automatic obs_t e_memwb();  e_memwb  = mk(4, 0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 0,1,1,0); endfunction
  function automatic obs_t e_memwr();  e_memwr  = mk(5, 1,1,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0,0,0); endfunction
  function automatic obs_t e_rtex();   e_rtex   = mk(6, 0,0,0,0, 2'd0, 1, 2'd0, 2'd2, 0,0,0,0); endfunction
  function automatic obs_t e_rtwb();   e_rtwb   = mk(7, 0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 1,0,1,0); endfunction
  function automatic obs_t e_beq(input logic p); e_beq = mk(8, 0,0,0,p, 2'd1, 1, 2'd0, 2'd1, 0,0,0,0); endfunction
  function automatic obs_t e_addiex(); e_addiex = mk(9, 0,0,0,0, 2'd0, 1, 2'd2, 2'd0, 0,0,0,0); endfunction
  function automatic obs_t e_addiwb(); e_addiwb = mk(10,0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0,1,0); endfunction
  function automatic obs_t e_jex();    e_jex    = mk(11,0,0,0,1, 2'd2, 0, 2'd0, 2'd0, 0,0,0,0); endfunction
  function automatic obs_t e_bne(input logic p); e_bne = mk(12,0,0,0,p, 2'd1, 1, 2'd0, 2'd1, 0,0,0,0); endfunction

  task automatic step(input logic r, input logic [5:0] o, input logic z, input logic m,
                      input obs_t e, input string nm);
    @(posedge clk);
    #1;
    reset = r; op = o; zero = z; mem_ready = m;
    sbq.push_back(e);
    nmq.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      obs_t  e, a;
      string nm;
      e  = sbq.pop_front();
      nm = nmq.pop_front();
      a  = {state_o, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb, aluop,
            regdst, memtoreg, regwrite, illegal_op};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s at %0t: got %h required %h", nm, $time, a, e);
      end
    end
  end

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         ADDI = 6'b001000, J = 6'b000010, BNE = 6'b000101, BAD = 6'b111111;

  initial begin
    // Reset held 3 cycles with mem_ready high: FETCH, strobes masked.
    repeat (3) step(0, RT, 0, 1, e_fetch(0), "rst_fetch");
    // R-type
    step(1, RT, 0, 1, e_fetch(1), "rt_fetch");
    step(1, RT, 0, 1, e_decode(0), "rt_decode");
    step(1, RT, 0, 1, e_rtex(), "rt_ex");
    step(1, RT, 0, 1, e_rtwb(), "rt_wb");
    // lw with two wait cycles in FETCH and MEMRD (9 cycles)
    step(1, LW, 0, 0, e_fetch(0), "lw_fetch_wait0");
    step(1, LW, 0, 0, e_fetch(0), "lw_fetch_wait1");
    step(1, LW, 0, 1, e_fetch(1), "lw_fetch_rdy");
    step(1, LW, 0, 1, e_decode(0), "lw_decode");
    step(1, LW, 0, 0, e_memadr(), "lw_memadr");
    step(1, LW, 0, 0, e_memrd(), "lw_memrd_wait0");
    step(1, LW, 0, 0, e_memrd(), "lw_memrd_wait1");
    step(1, LW, 0, 1, e_memrd(), "lw_memrd_rdy");
    step(1, LW, 0, 1, e_memwb(), "lw_memwb");
    // beq taken / not taken
    step(1, BEQ, 1, 1, e_fetch(1), "beq1_fetch");
    step(1, BEQ, 1, 1, e_decode(0), "beq1_decode");
    step(1, BEQ, 1, 1, e_beq(1), "beq_taken");
    step(1, BEQ, 0, 1, e_fetch(1), "beq0_fetch");
    step(1, BEQ, 0, 1, e_decode(0), "beq0_decode");
    step(1, BEQ, 0, 1, e_beq(0), "beq_not_taken");
    // sw, single-cycle MEMWR
    step(1, SW, 0, 1, e_fetch(1), "sw_fetch");
    step(1, SW, 0, 1, e_decode(0), "sw_decode");
    step(1, SW, 0, 1, e_memadr(), "sw_memadr");
    step(1, SW, 0, 1, e_memwr(), "sw_memwr");
    // sw with MEMWR stalled one cycle
    step(1, SW, 0, 1, e_fetch(1), "sw2_fetch");
    step(1, SW, 0, 1, e_decode(0), "sw2_decode");
    step(1, SW, 0, 0, e_memadr(), "sw2_memadr");
    step(1, SW, 0, 0, e_memwr(), "sw2_memwr_wait");
    step(1, SW, 0, 1, e_memwr(), "sw2_memwr_rdy");
    // addi and j
    step(1, ADDI, 0, 1, e_fetch(1), "addi_fetch");
    step(1, ADDI, 0, 1, e_decode(0), "addi_decode");
    step(1, ADDI, 0, 1, e_addiex(), "addi_ex");
    step(1, ADDI, 0, 1, e_addiwb(), "addi_wb");
    step(1, J, 0, 1, e_fetch(1), "j_fetch");
    step(1, J, 0, 1, e_decode(0), "j_decode");
    step(1, J, 0, 1, e_jex(), "j_ex");
    // illegal opcode
    step(1, BAD, 0, 1, e_fetch(1), "bad_fetch");
    step(1, BAD, 0, 1, e_decode(1), "bad_decode");
    // bne
    step(1, BNE, 0, 1, e_fetch(1), "bne_fetch");
`ifdef MC_CTRL_BNE_EN
    step(1, BNE, 0, 1, e_decode(0), "bne_decode");
    step(1, BNE, 0, 1, e_bne(1), "bne_taken");
    step(1, BNE, 1, 1, e_fetch(1), "bne1_fetch");
    step(1, BNE, 1, 1, e_decode(0), "bne1_decode");
    step(1, BNE, 1, 1, e_bne(0), "bne_not_taken");
`else
    step(1, BNE, 0, 1, e_decode(1), "bne_illegal");
`endif
    // Reset asserted mid-sw: abandoned, no memwrite
    step(1, SW, 0, 1, e_fetch(1), "ab_fetch");
    step(1, SW, 0, 1, e_decode(0), "ab_decode");
    step(1, SW, 0, 1, e_memadr(), "ab_memadr");
    step(0, SW, 0, 1, e_fetch(0), "ab_reset");
    step(1, RT, 0, 0, e_fetch(0), "ab_release");
    step(1, RT, 0, 1, e_fetch(1), "ab_refetch");
    step(1, RT, 0, 1, e_decode(0), "ab_decode2");

    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
